word_packer: RTL and testbench
==============================

WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of 33-bit entries (word plus last flag) in the output FIFO; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: a synchronous, active-low reset.
REQ-004 SHALL have port byteIn, input, 8 bits: the upstream byte.
REQ-005 SHALL have port byteInVal, input, 1 bit: byteIn is valid.
REQ-006 SHALL have port byteInLast, input, 1 bit: byteIn is the final byte of its packet.
REQ-007 SHALL have port byteInReady, output, 1 bit: this block can accept a byte.
REQ-008 SHALL have port dataOut, output, 32 bits: the packed word, feeding the parser's dataIn.
REQ-009 SHALL have port dataOutVal, output, 1 bit: dataOut is valid, feeding the parser's dataInVal.
REQ-010 SHALL have port dataOutLast, output, 1 bit: the word ends a packet, feeding the parser's dataInLast.
REQ-011 SHALL have port dataOutReady, input, 1 bit: the parser accepts the word, driven from the parser's dataInReady.

Function
REQ-012 SHALL accept a byte on any cycle where byteInVal and byteInReady are both 1.
REQ-013 SHALL drive byteInReady = !fifoFull, a registered-state function with no combinational path from dataOutReady.
REQ-014 SHALL pack bytes big-endian into an assembly register:
- the 1st byte of a word goes to [31:24], the 2nd to [23:16], the 3rd to [15:8], the 4th to [7:0];
- a 2-bit byte index tracks the next lane.
REQ-015 SHALL push {word, last} into the FIFO in the same cycle as the accepting handshake when either:
- the 4th byte of a word is accepted, or
- a byte with byteInLast=1 is accepted.
REQ-016 SHALL zero-fill unused lower lanes of a partial last word, and SHALL reset the byte index to 0 after every push.
REQ-017 SHALL present the head FIFO entry on dataOut/dataOutLast with dataOutVal = !fifoEmpty.
- Minimum latency: the word appears the cycle after the completing byte handshake.
REQ-018 SHALL pop the FIFO on any cycle where dataOutVal and dataOutReady are both 1.
REQ-019 SHALL allow a push and a pop in the same cycle; occupancy is then unchanged.
REQ-020 SHALL have the pointers wrap modulo FIFO_DEPTH and use a count of width $clog2(FIFO_DEPTH)+1.
REQ-021 SHALL hold dataOut, dataOutLast and dataOutVal stable while dataOutVal=1 and dataOutReady=0.
REQ-022 SHALL NOT accept a byte when the FIFO is full, even if that byte would not complete a word.
REQ-023 SHALL treat a single-byte packet as one word {byte, 24'h0} with last=1.

Reset
REQ-024 SHALL, when reset=0 at a rising edge, clear:
- the FIFO pointers and count;
- the byte index;
- the assembly register to 0.
REQ-025 SHALL drive these outputs while in reset and on the first cycle after it:
- dataOutVal=0, dataOutLast=0, dataOut=0;
- byteInReady=1 (from the cycle after reset releases).
REQ-026 SHALL discard any partially assembled word and all queued words when reset is asserted mid-packet; no residue from them appears after release.

Configuration
REQ-027 SHALL, when macro WORD_PACKER_STATS_EN is defined, add output pktCount, 16 bits:
- increments by 1 on each handshake with dataOutLast=1;
- wraps 16'hFFFF -> 0;
- resets to 0.
REQ-028 SHALL, when WORD_PACKER_STATS_EN is not defined, omit the pktCount port and counter entirely, with all other behaviour identical.

Verification
REQ-029 SHALL cover:
- stimulus: bytes 01..08, last on 08, dataOutReady=1;
- required response: words 32'h01020304 (last=0) then 32'h05060708 (last=1).
REQ-030 SHALL cover:
- stimulus: a 5-byte packet AA BB CC DD EE;
- required response: 32'hAABBCCDD then 32'hEE000000 with last=1.
REQ-031 SHALL cover:
- stimulus: dataOutReady=0 while 16 bytes stream in, FIFO_DEPTH=4;
- required response: byteInReady falls after the 4th word is pushed; dataOut holds 32'h..first word; no byte is lost after ready is restored.
REQ-032 SHALL cover:
- stimulus: reset=0 for one cycle after 2 bytes of a packet;
- required response: the next packet 11 22 33 44 (last) yields exactly 32'h11223344 with no stale lanes.
REQ-033 SHALL cover:
- stimulus: a single-byte packet 7F;
- required response: 32'h7F000000 with last=1, emitted one cycle after the handshake.
REQ-034 SHALL cover, with WORD_PACKER_STATS_EN defined:
- stimulus: 3 packets;
- required response: pktCount=3.
- stimulus: force pktCount to 16'hFFFF, then send one packet;
- required response: pktCount=0.

Source files
------------

// File: rtl/word_packer.sv
// Byte-to-word packer: big-endian assembly of a byte stream into 32-bit words, queued with a
// per-word last flag in a small FIFO. Define WORD_PACKER_STATS_EN to add the pktCount output.
module word_packer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  byteIn,
   input  logic        byteInVal,
   input  logic        byteInLast,
   output logic        byteInReady,
   output logic [31:0] dataOut,
   output logic        dataOutVal,
   output logic        dataOutLast,
   input  logic        dataOutReady
`ifdef WORD_PACKER_STATS_EN
   ,
   output logic [15:0] pktCount
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [32:0]      fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [CNT_W-1:0] count;
   logic [31:0]      asmReg;
   logic [1:0]       byteIdx;
   logic [31:0]      laneWord;
   logic [32:0]      headEntry;
   logic             fifoFull;
   logic             fifoEmpty;
   logic             byteAccept;
   logic             push;
   logic             pop;

   assign fifoFull   = (count == CNT_W'(FIFO_DEPTH));
   assign fifoEmpty  = (count == '0);
   assign byteInReady = !fifoFull;
   assign byteAccept = byteInVal && byteInReady;
   assign push       = byteAccept && ((byteIdx == 2'd3) || byteInLast);
   assign pop        = dataOutVal && dataOutReady;

   // Lanes at and below byteIdx are always zero in asmReg (it is cleared on every push),
   // so a partial last word comes out zero-filled without extra masking.
   always_comb begin
      laneWord = asmReg;
      case (byteIdx)
         2'd0:    laneWord[31:24] = byteIn;
         2'd1:    laneWord[23:16] = byteIn;
         2'd2:    laneWord[15:8]  = byteIn;
         default: laneWord[7:0]   = byteIn;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wrPtr   <= '0;
         rdPtr   <= '0;
         count   <= '0;
         byteIdx <= 2'd0;
         asmReg  <= '0;
      end else begin
         if (byteAccept) begin
            if (push) begin
               asmReg  <= '0;
               byteIdx <= 2'd0;
            end else begin
               asmReg  <= laneWord;
               byteIdx <= byteIdx + 2'd1;
            end
         end
         if (push) wrPtr <= wrPtr + PTR_W'(1);
         if (pop)  rdPtr <= rdPtr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset && push) fifoMem[wrPtr] <= {laneWord, byteInLast};
   end

   // Gate the head with fifoEmpty so stale storage never leaks out after reset.
   assign headEntry   = fifoMem[rdPtr];
   assign dataOutVal  = !fifoEmpty;
   assign dataOut     = fifoEmpty ? 32'h0 : headEntry[32:1];
   assign dataOutLast = fifoEmpty ? 1'b0  : headEntry[0];

`ifdef WORD_PACKER_STATS_EN
   logic [15:0] pktCountReg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         pktCountReg <= 16'h0;
      end else if (pop && dataOutLast) begin
         pktCountReg <= pktCountReg + 16'h1;
      end
   end

   assign pktCount = pktCountReg;
`endif

endmodule

// File: tb/tb_word_packer.sv
// Scoreboard bench for word_packer: stimulus pushes hand-computed words, a negedge monitor pops
// and compares on every output handshake. Stats checks run when WORD_PACKER_STATS_EN is defined.
module tb_word_packer;

   logic        clk;
   logic        reset;
   logic [7:0]  byteIn;
   logic        byteInVal;
   logic        byteInLast;
   logic        byteInReady;
   logic [31:0] dataOut;
   logic        dataOutVal;
   logic        dataOutLast;
   logic        dataOutReady;
`ifdef WORD_PACKER_STATS_EN
   logic [15:0] pktCount;
`endif

   int checks;
   int failures;
   logic [32:0] expQ[$];

   word_packer #(.FIFO_DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .byteIn       (byteIn),
      .byteInVal    (byteInVal),
      .byteInLast   (byteInLast),
      .byteInReady  (byteInReady),
      .dataOut      (dataOut),
      .dataOutVal   (dataOutVal),
      .dataOutLast  (dataOutLast),
      .dataOutReady (dataOutReady)
`ifdef WORD_PACKER_STATS_EN
      ,
      .pktCount     (pktCount)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted output word must match the oldest expectation.
   always @(negedge clk) begin
      logic [32:0] e;
      if (reset && dataOutVal && dataOutReady) begin
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%0h last=%0b required=none", dataOut, dataOutLast);
         end else begin
            e = expQ.pop_front();
            chk("word_data", {32'h0, dataOut}, {32'h0, e[32:1]});
            chk("word_last", {63'h0, dataOutLast}, {63'h0, e[0]});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expectWord(input logic [31:0] w, input logic l);
      expQ.push_back({w, l});
   endtask

   task automatic sendByte(input logic [7:0] b, input logic l);
      int n;
      byteIn     = b;
      byteInLast = l;
      byteInVal  = 1'b1;
      n = 0;
      while (!byteInReady && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) chk("send_timeout", 64'(n), 64'd0);
      tick();
      byteInVal  = 1'b0;
      byteInLast = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      chk("drain_queue_empty", 64'(expQ.size()), 64'd0);
   endtask

   task automatic pulseReset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      reset        = 1'b0;
      byteIn       = 8'h0;
      byteInVal    = 1'b0;
      byteInLast   = 1'b0;
      dataOutReady = 1'b1;

      // Reset state
      repeat (3) tick();
      chk("rst_val",  {63'h0, dataOutVal}, 64'd0);
      chk("rst_last", {63'h0, dataOutLast}, 64'd0);
      chk("rst_data", {32'h0, dataOut}, 64'd0);
      reset = 1'b1;
      chk("post_rst_ready", {63'h0, byteInReady}, 64'd1);
      chk("post_rst_val", {63'h0, dataOutVal}, 64'd0);

      // Two full words, last on the 8th byte
      expectWord(32'h01020304, 1'b0);
      expectWord(32'h05060708, 1'b1);
      for (int i = 1; i <= 8; i++) sendByte(8'(i), i == 8);
      drain();

      // Five-byte packet: partial tail is zero-filled
      expectWord(32'hAABBCCDD, 1'b0);
      expectWord(32'hEE000000, 1'b1);
      sendByte(8'hAA, 1'b0);
      sendByte(8'hBB, 1'b0);
      sendByte(8'hCC, 1'b0);
      sendByte(8'hDD, 1'b0);
      sendByte(8'hEE, 1'b1);
      drain();

      // Single-byte packet visible the cycle after its handshake
      expectWord(32'h7F000000, 1'b1);
      sendByte(8'h7F, 1'b1);
      chk("lat_val",  {63'h0, dataOutVal}, 64'd1);
      chk("lat_data", {32'h0, dataOut}, 64'h7F000000);
      chk("lat_last", {63'h0, dataOutLast}, 64'd1);
      drain();

      // Backpressure: FIFO fills with 4 words, then an extra byte waits for space
      dataOutReady = 1'b0;
      expectWord(32'h10111213, 1'b0);
      expectWord(32'h14151617, 1'b0);
      expectWord(32'h18191A1B, 1'b0);
      expectWord(32'h1C1D1E1F, 1'b1);
      expectWord(32'h20000000, 1'b1);
      for (int i = 0; i < 16; i++) begin
         sendByte(8'(8'h10 + i), i == 15);
         if (i == 11) chk("ready_at_3_words", {63'h0, byteInReady}, 64'd1);
      end
      chk("ready_full", {63'h0, byteInReady}, 64'd0);
      byteIn     = 8'h20;
      byteInLast = 1'b1;
      byteInVal  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_ready", {63'h0, byteInReady}, 64'd0);
         chk("stall_val",   {63'h0, dataOutVal}, 64'd1);
         chk("stall_data",  {32'h0, dataOut}, 64'h10111213);
         chk("stall_last",  {63'h0, dataOutLast}, 64'd0);
      end
      dataOutReady = 1'b1;
      begin
         int n;
         n = 0;
         while (!byteInReady && n < 50) begin
            tick();
            n++;
         end
         chk("ready_restored", {63'h0, byteInReady}, 64'd1);
      end
      tick();
      byteInVal  = 1'b0;
      byteInLast = 1'b0;
      drain();

      // Reset mid-packet discards the partial word
      sendByte(8'h55, 1'b0);
      sendByte(8'h66, 1'b0);
      pulseReset();
      chk("midrst_val", {63'h0, dataOutVal}, 64'd0);
      expectWord(32'h11223344, 1'b1);
      sendByte(8'h11, 1'b0);
      sendByte(8'h22, 1'b0);
      sendByte(8'h33, 1'b0);
      sendByte(8'h44, 1'b1);
      drain();

      // Reset also discards queued words
      dataOutReady = 1'b0;
      for (int i = 0; i < 6; i++) sendByte(8'(8'h90 + i), 1'b0);
      chk("queued_val", {63'h0, dataOutVal}, 64'd1);
      pulseReset();
      chk("qrst_val",  {63'h0, dataOutVal}, 64'd0);
      chk("qrst_data", {32'h0, dataOut}, 64'd0);
      dataOutReady = 1'b1;
      expectWord(32'hC1000000, 1'b1);
      sendByte(8'hC1, 1'b1);
      drain();

`ifdef WORD_PACKER_STATS_EN
      pulseReset();
      chk("stats_rst", {48'h0, pktCount}, 64'd0);
      expectWord(32'hA1000000, 1'b1);
      expectWord(32'hA2A30000, 1'b1);
      expectWord(32'hA4000000, 1'b1);
      sendByte(8'hA1, 1'b1);
      sendByte(8'hA2, 1'b0);
      sendByte(8'hA3, 1'b1);
      sendByte(8'hA4, 1'b1);
      drain();
      tick();
      chk("stats_three", {48'h0, pktCount}, 64'd3);
      force dut.pktCountReg = 16'hFFFF;
      tick();
      release dut.pktCountReg;
      chk("stats_forced", {48'h0, pktCount}, 64'hFFFF);
      expectWord(32'hB1000000, 1'b1);
      sendByte(8'hB1, 1'b1);
      drain();
      tick();
      chk("stats_wrap", {48'h0, pktCount}, 64'd0);
`endif

      repeat (3) tick();
      chk("final_queue_empty", 64'(expQ.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
